// File: rtl/bcd_counter_n.sv
// bcd_counter_n: multi-digit BCD up/down counter.
// Supports synchronous clear, parallel load and single-step counting.
// Limit behaviour is selectable: wrap (WRAP=1) or saturate (WRAP=0).
// A one-cycle tick_out pulse marks every carry/borrow out of the top digit.
module bcd_counter_n #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset_n,
  input  logic                  tick_in,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick_out,
  output logic                  is_zero
);

  localparam int W = 4 * DIGITS;

  // A load nibble above 9 is not a legal BCD digit; pin it to 9.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Apply the digit clamp to every nibble of a packed BCD word.
  function automatic logic [W-1:0] clamp_word(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = clamp_digit(v[4*i +: 4]);
    end
    return r;
  endfunction

  logic [W-1:0] step_val;
  logic         limit;
  logic [W-1:0] count_nxt;
  logic         tick_nxt;
  logic [3:0]   dig;
  logic         carry;

  // Ripple a +1/-1 decimal step through all digits; carry out marks the limit.
  always_comb begin
    step_val = count;
    carry    = 1'b1;
    dig      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (dig == 4'd9) begin
            dig = 4'd0;
          end else begin
            dig   = dig + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            dig = 4'd9;
          end else begin
            dig   = dig - 4'd1;
            carry = 1'b0;
          end
        end
      end
      step_val[4*i +: 4] = dig;
    end
    limit = carry;
  end

  // Select next count by priority clear > load > tick; saturate when WRAP=0.
  always_comb begin
    count_nxt = count;
    tick_nxt  = 1'b0;
    if (clear) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = clamp_word(load_value);
    end else if (tick_in) begin
      tick_nxt = limit;
      if (!limit || WRAP) begin
        count_nxt = step_val;
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      count    <= '0;
      tick_out <= 1'b0;
    end else begin
      count    <= count_nxt;
      tick_out <= tick_nxt;
    end
  end

  assign is_zero = (count == '0);

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed testbench for bcd_counter_n across four parameter sets.
module tb_bcd_counter_n;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  // Instance A: DIGITS=4, WRAP=1
  logic        tick_a, up_a, clr_a, ld_a;
  logic [15:0] lv_a, cnt_a;
  logic        to_a, z_a;
  // Instance B: DIGITS=2, WRAP=1
  logic        tick_b, up_b, clr_b, ld_b;
  logic [7:0]  lv_b, cnt_b;
  logic        to_b, z_b;
  // Instance C: DIGITS=2, WRAP=0
  logic        tick_c, up_c, clr_c, ld_c;
  logic [7:0]  lv_c, cnt_c;
  logic        to_c, z_c;
  // Instance D: DIGITS=3, WRAP=1
  logic        tick_d, up_d, clr_d, ld_d;
  logic [11:0] lv_d, cnt_d;
  logic        to_d, z_d;

  bcd_counter_n #(.DIGITS(4), .WRAP(1'b1)) u_a (
    .sys_clk(clk), .sys_reset_n(rst_n), .tick_in(tick_a), .up(up_a),
    .clear(clr_a), .load(ld_a), .load_value(lv_a), .count(cnt_a),
    .tick_out(to_a), .is_zero(z_a));

  bcd_counter_n #(.DIGITS(2), .WRAP(1'b1)) u_b (
    .sys_clk(clk), .sys_reset_n(rst_n), .tick_in(tick_b), .up(up_b),
    .clear(clr_b), .load(ld_b), .load_value(lv_b), .count(cnt_b),
    .tick_out(to_b), .is_zero(z_b));

  bcd_counter_n #(.DIGITS(2), .WRAP(1'b0)) u_c (
    .sys_clk(clk), .sys_reset_n(rst_n), .tick_in(tick_c), .up(up_c),
    .clear(clr_c), .load(ld_c), .load_value(lv_c), .count(cnt_c),
    .tick_out(to_c), .is_zero(z_c));

  bcd_counter_n #(.DIGITS(3), .WRAP(1'b1)) u_d (
    .sys_clk(clk), .sys_reset_n(rst_n), .tick_in(tick_d), .up(up_d),
    .clear(clr_d), .load(ld_d), .load_value(lv_d), .count(cnt_d),
    .tick_out(to_d), .is_zero(z_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b1;
    {tick_a, up_a, clr_a, ld_a} = '0; lv_a = '0;
    {tick_b, up_b, clr_b, ld_b} = '0; lv_b = '0;
    {tick_c, up_c, clr_c, ld_c} = '0; lv_c = '0;
    {tick_d, up_d, clr_d, ld_d} = '0; lv_d = '0;
    #2;
    do_reset();

    // Reset state
    check("rst_count", 32'(cnt_a), 32'h0);
    check("rst_tick",  32'(to_a), 32'h0);
    check("rst_zero",  32'(z_a), 32'h1);

    // 15 spaced up-ticks -> 0x0015, tick_out never high
    up_a = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick_a = 1'b1;
      step();
      tick_a = 1'b0;
      check("spaced_tout", 32'(to_a), 32'h0);
      repeat (5) step();
    end
    check("spaced_count", 32'(cnt_a), 32'h0015);
    check("spaced_zero",  32'(z_a), 32'h0);

    // Wrap from zero downwards, then back up
    do_reset();
    up_a = 1'b0; tick_a = 1'b1;
    step();
    check("dn_wrap_count", 32'(cnt_a), 32'h9999);
    check("dn_wrap_tout",  32'(to_a), 32'h1);
    up_a = 1'b1;
    step();
    check("up_wrap_count", 32'(cnt_a), 32'h0000);
    check("up_wrap_tout",  32'(to_a), 32'h1);
    check("up_wrap_zero",  32'(z_a), 32'h1);
    tick_a = 1'b0;
    step();
    check("idle_tout", 32'(to_a), 32'h0);
    check("idle_hold", 32'(cnt_a), 32'h0000);

    // Count to 7, then asynchronous reset mid-cycle
    up_a = 1'b1; tick_a = 1'b1;
    repeat (7) step();
    check("cnt7", 32'(cnt_a), 32'h0007);
    rst_n = 1'b0;
    #2;
    check("async_rst", 32'(cnt_a), 32'h0000);
    step();
    step();
    check("rst_blocks_tick", 32'(cnt_a), 32'h0000);
    rst_n = 1'b1;
    step();
    check("first_after_rst", 32'(cnt_a), 32'h0001);
    tick_a = 1'b0;

    // Instance B: load 0x98, two up ticks wrap through 0x99 to 0x00
    ld_b = 1'b1; lv_b = 8'h98;
    step();
    ld_b = 1'b0;
    check("b_load", 32'(cnt_b), 32'h98);
    up_b = 1'b1; tick_b = 1'b1;
    step();
    check("b_99", 32'(cnt_b), 32'h99);
    check("b_99_tout", 32'(to_b), 32'h0);
    step();
    tick_b = 1'b0;
    check("b_00", 32'(cnt_b), 32'h00);
    check("b_00_tout", 32'(to_b), 32'h1);
    check("b_00_zero", 32'(z_b), 32'h1);
    step();
    check("b_tout_once", 32'(to_b), 32'h0);
    // Illegal nibbles load as 9
    ld_b = 1'b1; lv_b = 8'hAF;
    step();
    ld_b = 1'b0;
    check("b_clamp", 32'(cnt_b), 32'h99);

    // Instance C: saturating down-count from 0x01
    ld_c = 1'b1; lv_c = 8'h01;
    step();
    ld_c = 1'b0;
    up_c = 1'b0; tick_c = 1'b1;
    step();
    check("c_t1", 32'(cnt_c), 32'h00);
    check("c_t1_tout", 32'(to_c), 32'h0);
    step();
    check("c_t2", 32'(cnt_c), 32'h00);
    check("c_t2_tout", 32'(to_c), 32'h1);
    step();
    tick_c = 1'b0;
    check("c_t3", 32'(cnt_c), 32'h00);
    check("c_t3_tout", 32'(to_c), 32'h1);
    step();
    check("c_idle_tout", 32'(to_c), 32'h0);
    // Saturate at the top
    ld_c = 1'b1; lv_c = 8'h99;
    step();
    ld_c = 1'b0;
    check("c_load_tout", 32'(to_c), 32'h0);
    up_c = 1'b1; tick_c = 1'b1;
    step();
    tick_c = 1'b0;
    check("c_sat_up", 32'(cnt_c), 32'h99);
    check("c_sat_up_tout", 32'(to_c), 32'h1);

    // Instance D: clamped load, carry ripple, priority
    ld_d = 1'b1; lv_d = 12'h1A9;
    step();
    ld_d = 1'b0;
    check("d_load", 32'(cnt_d), 32'h199);
    up_d = 1'b1; tick_d = 1'b1;
    step();
    tick_d = 1'b0;
    check("d_ripple", 32'(cnt_d), 32'h200);
    // Borrow ripple after a direction change
    up_d = 1'b0; tick_d = 1'b1;
    step();
    tick_d = 1'b0;
    check("d_borrow", 32'(cnt_d), 32'h199);
    // Load beats tick
    ld_d = 1'b1; lv_d = 12'h345; tick_d = 1'b1; up_d = 1'b1;
    step();
    check("d_load_prio", 32'(cnt_d), 32'h345);
    // Clear beats load and tick
    clr_d = 1'b1; lv_d = 12'h777;
    step();
    clr_d = 1'b0; ld_d = 1'b0; tick_d = 1'b0;
    check("d_clear_prio", 32'(cnt_d), 32'h000);
    check("d_clear_tout", 32'(to_d), 32'h0);
    check("d_clear_zero", 32'(z_d), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
